// File: rtl/alu_seq_stage.sv
// alu_seq_stage: sequences one request at a time through an external
// combinational ALU. It registers the operands, waits a per-opcode number of
// cycles, captures the result and holds it until downstream accepts it.
// Optional feature macro: ALU_NZP_EN adds the out_nzp {N,Z,P} flag output.
module alu_seq_stage #(
   parameter int LAT_ADD = 1,   // legal 1..7
   parameter int LAT_SUB = 1,   // legal 1..7
   parameter int LAT_MUL = 2,   // legal 1..7
   parameter int LAT_DIV = 4    // legal 1..7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_rs,
   input  logic [7:0] in_rt,
   input  logic [1:0] in_op,
   output logic [7:0] alu_rs,
   output logic [7:0] alu_rt,
   output logic [1:0] alu_op,
   input  logic [7:0] alu_result,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_div0
`ifdef ALU_NZP_EN
   ,
   output logic [2:0] out_nzp
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [2:0] r_cnt;
   logic [7:0] r_alu_rs;
   logic [7:0] r_alu_rt;
   logic [1:0] r_alu_op;
   logic       r_out_valid;
   logic [7:0] r_out_data;
   logic       r_out_div0;

   logic       w_in_ready;
   logic       w_accept;
   logic       w_retire;
   logic [2:0] w_lat;
   logic       w_div0;
   logic [7:0] w_cap;

   // Ready is combinational so a retiring result and a new request can share
   // one edge; it is forced low while reset is asserted.
   assign w_in_ready = ~reset & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
   assign w_accept   = in_valid & w_in_ready;
   assign w_retire   = r_out_valid & out_ready;

   // Divide-by-zero is flagged from the registered operands, not from the ALU.
   assign w_div0 = (r_alu_op == 2'b11) && (r_alu_rt == 8'd0);
   assign w_cap  = w_div0 ? 8'hFF : alu_result;

   // Busy-cycle count for the incoming opcode.
   always_comb begin
      w_lat = 3'(LAT_ADD);
      case (in_op)
         2'b00:   w_lat = 3'(LAT_ADD);
         2'b01:   w_lat = 3'(LAT_SUB);
         2'b10:   w_lat = 3'(LAT_MUL);
         default: w_lat = 3'(LAT_DIV);
      endcase
   end

   // Request sequencer: IDLE -> BUSY (count down) -> DONE (hold until taken).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= 3'd0;
         r_alu_rs    <= 8'd0;
         r_alu_rt    <= 8'd0;
         r_alu_op    <= 2'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'd0;
         r_out_div0  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_alu_rs <= in_rs;
                  r_alu_rt <= in_rt;
                  r_alu_op <= in_op;
                  r_cnt    <= w_lat;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == 3'd1) begin
                  r_out_data  <= w_cap;
                  r_out_div0  <= w_div0;
                  r_out_valid <= 1'b1;
                  r_cnt       <= 3'd0;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            DONE: begin
               if (w_retire) begin
                  r_out_valid <= 1'b0;
                  if (w_accept) begin
                     // zero-bubble handoff: retire and accept on the same edge
                     r_alu_rs <= in_rs;
                     r_alu_rt <= in_rt;
                     r_alu_op <= in_op;
                     r_cnt    <= w_lat;
                     r_state  <= BUSY;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cnt       <= 3'd0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_NZP_EN
   logic [2:0] r_out_nzp;
   logic [2:0] w_nzp;

   // Exactly one flag set: negative, zero, or positive.
   assign w_nzp = {w_cap[7], (w_cap == 8'd0), (~w_cap[7] & (w_cap != 8'd0))};

   // Flags captured on the same edge as out_data so they always agree.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_nzp <= 3'b000;
      end else if ((r_state == BUSY) && (r_cnt == 3'd1)) begin
         r_out_nzp <= w_nzp;
      end
   end

   assign out_nzp = r_out_nzp;
`endif

   assign in_ready  = w_in_ready;
   assign alu_rs    = r_alu_rs;
   assign alu_rt    = r_alu_rt;
   assign alu_op    = r_alu_op;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_div0  = r_out_div0;

endmodule
